// File: rtl/motor_step_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : motor_step_gen_if
// Brief    : Channel request/status and position readback bundle for
//            motor_step_gen. The master drives requests; the slave is the generator.
// Revision : 1.0
// ============================================================================
interface motor_step_gen_if;
    logic [7:0]  step_req;
    logic [7:0]  dir_req;
    logic [7:0]  in_aborts;
    logic [7:0]  clear;
    logic [7:0]  steps;
    logic [7:0]  dirs;
    logic [7:0]  busy;
    logic [7:0]  aborted;
    logic [7:0]  missed;
    logic [2:0]  pos_sel;
    logic        pos_load;
    logic [31:0] pos_load_val;
    logic [31:0] pos_out;

    modport master (
        output step_req, dir_req, in_aborts, clear, pos_sel, pos_load, pos_load_val,
        input  steps, dirs, busy, aborted, missed, pos_out
    );

    modport slave (
        input  step_req, dir_req, in_aborts, clear, pos_sel, pos_load, pos_load_val,
        output steps, dirs, busy, aborted, missed, pos_out
    );
endinterface
`default_nettype wire

// File: rtl/motor_step_gen.sv
`default_nettype none
// ============================================================================
// Module   : motor_step_gen
// Brief    : Eight independent step/direction pulse generators with direction
//            setup time, sticky abort/missed flags and optional position
//            counters (enabled by defining MOTOR_STEP_GEN_POSCNT_EN).
// Revision : 1.0
// ============================================================================
module motor_step_gen #(
    parameter int PULSE_W   = 4,
    parameter int DIR_SETUP = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    motor_step_gen_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    localparam logic [7:0] c_pulse_last = 8'(PULSE_W - 1);
    localparam logic [7:0] c_setup_last = 8'(DIR_SETUP - 1);

    wire [7:0] w_steps;
    wire [7:0] w_dirs;
    wire [7:0] w_busy;
    wire [7:0] w_aborted;
    wire [7:0] w_missed;
    wire [7:0] w_rise;

    for (genvar i = 0; i < 8; i++) begin : g_ch
        state_t     r_state;
        state_t     w_state_nxt;
        logic [7:0] r_cnt;
        logic [7:0] w_cnt_nxt;
        logic       r_step;
        logic       w_step_nxt;
        logic       r_dir;
        logic       w_dir_nxt;
        logic       r_aborted;
        logic       r_missed;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_step    <= 1'b0;
                r_dir     <= 1'b0;
                r_aborted <= 1'b0;
                r_missed  <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_step    <= w_step_nxt;
                r_dir     <= w_dir_nxt;
                // A same-cycle abort beats clear; a busy-time request only counts as missed when not aborted.
                r_aborted <= bus.in_aborts[i] | (r_aborted & ~bus.clear[i]);
                r_missed  <= (bus.step_req[i] & (r_state != ST_IDLE) & ~r_aborted)
                           | (r_missed & ~bus.clear[i]);
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_step_nxt  = r_step;
            w_dir_nxt   = r_dir;
            case (r_state)
                ST_IDLE: begin
                    if (bus.step_req[i] && !r_aborted) begin
                        if (bus.dir_req[i] == r_dir) begin
                            w_state_nxt = ST_HIGH;
                            w_step_nxt  = 1'b1;
                            w_cnt_nxt   = c_pulse_last;
                        end else begin
                            w_state_nxt = ST_SETUP;
                            w_dir_nxt   = bus.dir_req[i];
                            w_cnt_nxt   = c_setup_last;
                        end
                    end
                end
                ST_SETUP: begin
                    // No pulse has been issued yet, so an abort can cancel cleanly here.
                    if (bus.in_aborts[i] || r_aborted) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_cnt == 8'd0) begin
                        w_state_nxt = ST_HIGH;
                        w_step_nxt  = 1'b1;
                        w_cnt_nxt   = c_pulse_last;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (r_cnt == 8'd0) begin
                        w_state_nxt = ST_LOW;
                        w_step_nxt  = 1'b0;
                        w_cnt_nxt   = c_pulse_last;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
                ST_LOW: begin
                    if (r_cnt == 8'd0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_step_nxt  = 1'b0;
                end
            endcase
        end

        assign w_steps[i]   = r_step;
        assign w_dirs[i]    = r_dir;
        assign w_busy[i]    = (r_state != ST_IDLE);
        assign w_aborted[i] = r_aborted;
        assign w_missed[i]  = r_missed;
        assign w_rise[i]    = w_step_nxt & ~r_step;
    end

    assign bus.steps   = w_steps;
    assign bus.dirs    = w_dirs;
    assign bus.busy    = w_busy;
    assign bus.aborted = w_aborted;
    assign bus.missed  = w_missed;

`ifdef MOTOR_STEP_GEN_POSCNT_EN
    logic [31:0] r_pos [8];
    logic [31:0] r_pos_out;

    // Direction is already settled when a rise is issued, so the current dirs bit is the count sign.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                r_pos[k] <= '0;
            end
            r_pos_out <= '0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (bus.pos_load && (bus.pos_sel == 3'(k))) begin
                    r_pos[k] <= bus.pos_load_val;
                end else if (w_rise[k]) begin
                    r_pos[k] <= w_dirs[k] ? (r_pos[k] + 32'd1) : (r_pos[k] - 32'd1);
                end
            end
            r_pos_out <= r_pos[bus.pos_sel];
        end
    end

    assign bus.pos_out = r_pos_out;
`else
    wire w_unused_pos = ^{bus.pos_sel, bus.pos_load, bus.pos_load_val, w_rise};

    assign bus.pos_out = '0;
`endif

endmodule
`default_nettype wire
